// File: rtl/topk_delay_buffer.sv
// Programmable-depth delay line for wide lane vectors: each accepted vector
// re-emerges exactly D accepts later, in the same cycle its slot is overwritten.
module topk_delay_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 32,
  parameter int MAX_DEPTH  = 16,
  localparam int DW        = DATA_WIDTH * LANES,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic               flush,
  input  logic               i_valid,
  input  logic [DW-1:0]      i_data,
  output logic               o_valid,
  output logic [DW-1:0]      o_data,
  output logic [DEPTH_W-1:0] o_fill,
  output logic               cfg_err
);

  localparam int PTR_W = $clog2(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  typedef enum logic {FILLING, STREAMING} state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DW-1:0]      mem_q [MAX_DEPTH];

  logic               accept;
  logic               cfg_ok;
  logic [DEPTH_W-1:0] depth_eff;
  logic [PTR_W-1:0]   wptr;

  always_comb begin
    accept    = i_valid & ~flush;
    // A new depth is only legal when the line will be empty after this edge.
    cfg_ok    = cfg_load && ((fill_q == '0) || flush) &&
                (cfg_depth != '0) && (cfg_depth <= MAX_D);
    depth_eff = cfg_ok ? cfg_depth : depth_q;
    wptr      = cfg_ok ? '0 : ptr_q;

    depth_d   = depth_eff;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    cfg_err_d = cfg_load & ~cfg_ok;

    if (flush) begin
      ptr_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      ptr_d  = (DEPTH_W'(wptr) == depth_eff - DEPTH_W'(1)) ? '0 : wptr + PTR_W'(1);
      fill_d = (fill_q < depth_eff) ? fill_q + DEPTH_W'(1) : fill_q;
    end else if (cfg_ok) begin
      ptr_d  = '0;
    end

    state_d = (fill_d == depth_d) ? STREAMING : FILLING;

    // When full, the slot about to be written holds the oldest vector.
    o_valid = accept && (state_q == STREAMING);
    o_data  = (state_q == STREAMING) ? mem_q[ptr_q] : '0;
    o_fill  = fill_q;
    cfg_err = cfg_err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILLING;
      depth_q   <= MAX_D;
      fill_q    <= '0;
      ptr_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      fill_q    <= fill_d;
      ptr_q     <= ptr_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wptr] <= i_data;
    end
  end

endmodule

// File: tb/tb_topk_delay_buffer.sv
// Directed bench for topk_delay_buffer: a queue model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_topk_delay_buffer;
  localparam int DATA_WIDTH = 32;
  localparam int LANES      = 32;
  localparam int MAX_DEPTH  = 16;
  localparam int DW         = DATA_WIDTH * LANES;
  localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [DEPTH_W-1:0] cfg_depth = '0;
  logic               flush = 1'b0;
  logic               i_valid = 1'b0;
  logic [DW-1:0]      i_data = '0;
  logic               o_valid;
  logic [DW-1:0]      o_data;
  logic [DEPTH_W-1:0] o_fill;
  logic               cfg_err;

  topk_delay_buffer #(
    .DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_depth(cfg_depth),
    .flush(flush), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .o_fill(o_fill), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  // Model: the stored vectors oldest-first, the active depth, pending cfg_err.
  logic [DW-1:0] q[$];
  int            m_d     = MAX_DEPTH;
  bit            exp_err = 1'b0;

  bit s_v, s_e;
  int s_lane, s_fill;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    chk(name, DW'(act), DW'(exp));
  endtask

  function automatic logic [DW-1:0] vec(input int n);
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(n);
    return v;
  endfunction

  task automatic model_update();
    bit ok;
    ok = cfg_load && ((q.size() == 0) || flush) && (cfg_depth >= 1) && (cfg_depth <= MAX_DEPTH);
    exp_err = cfg_load && !ok;
    if (flush) q.delete();
    if (ok) m_d = int'(cfg_depth);
    if (i_valid && !flush) begin
      if (q.size() == m_d) void'(q.pop_front());
      q.push_back(i_data);
    end
    $display("xact v=%0d lane0=%0d flush=%0d cfg=%0d/%0d -> D=%0d stored=%0d",
             i_valid, i_data[DATA_WIDTH-1:0], flush, cfg_load, cfg_depth, m_d, q.size());
  endtask

  task automatic step(input bit v, input int n, input bit fl = 1'b0,
                      input bit cl = 1'b0, input int cd = 0);
    i_valid   = v;
    i_data    = v ? vec(n) : '0;
    flush     = fl;
    cfg_load  = cl;
    cfg_depth = DEPTH_W'(cd);
    @(negedge clk);
    s_v    = o_valid;
    s_lane = int'(o_data[DATA_WIDTH-1:0]);
    s_fill = int'(o_fill);
    s_e    = cfg_err;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-cycle comparison against the queue model.
  always @(negedge clk) begin
    if (run && rst) begin
      bit full;
      logic [DW-1:0] ed;
      full = (q.size() == m_d);
      ed   = '0;
      if (full) ed = q[0];
      chk("o_fill", DW'(o_fill), DW'(q.size()));
      chk("o_valid", DW'(o_valid), DW'(i_valid && !flush && full));
      chk("o_data", o_data, ed);
      chk("cfg_err", DW'(cfg_err), DW'(exp_err));
    end
  end

  initial begin
    #1 rst = 1'b0;
    i_valid = 1'b1;
    i_data  = vec(3);
    #2;
    lit("rst_fill", int'(o_fill), 0);
    lit("rst_valid", int'(o_valid), 0);
    chk("rst_data", o_data, '0);
    lit("rst_err", int'(cfg_err), 0);
    i_valid = 1'b0;
    i_data  = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    run = 1'b1;

    // Default depth 16, lanes = n
    for (int n = 1; n <= 20; n++) begin
      step(1, n);
      if (n <= 16) lit("d16_noval", int'(s_v), 0);
      if (n >= 17) begin
        lit("d16_val", int'(s_v), 1);
        lit("d16_fill", s_fill, 16);
      end
      if (n == 17) lit("d16_first", s_lane, 1);
      if (n == 20) lit("d16_a20", s_lane, 4);
    end

    // Rejected cfg while non-empty; depth must stay 16
    step(0, 0, 1);
    for (int n = 1; n <= 5; n++) step(1, n);
    step(0, 0, 0, 1, 4);
    lit("err_pre", int'(s_e), 0);
    step(0, 0);
    lit("err_busy", int'(s_e), 1);
    lit("err_fill", s_fill, 5);
    step(0, 0);
    lit("err_once", int'(s_e), 0);
    for (int n = 6; n <= 17; n++) begin
      step(1, n);
      lit("keep16_v", int'(s_v), (n == 17) ? 1 : 0);
    end
    lit("keep16_lane", s_lane, 1);

    // Out-of-range depths at empty
    step(0, 0, 1, 1, 0);
    step(0, 0);
    lit("err_d0", int'(s_e), 1);
    step(0, 0, 0, 1, 17);
    step(0, 0);
    lit("err_d17", int'(s_e), 1);

    // D=3 with idle gaps
    step(0, 0, 0, 1, 3);
    step(1, 1); lit("d3_a1", int'(s_v), 0);
    step(0, 0); lit("d3_idle", int'(s_v), 0);
    step(0, 0);
    step(1, 2); lit("d3_a2", int'(s_v), 0);
    step(0, 0);
    step(1, 3); lit("d3_a3", int'(s_v), 0);
    step(0, 0);
    step(0, 0); lit("d3_idle2", int'(s_v), 0);
    step(1, 4);
    lit("d3_a4_v", int'(s_v), 1);
    lit("d3_a4_lane", s_lane, 1);

    // cfg_load together with the first accept
    step(0, 0, 1);
    step(1, 11, 0, 1, 2); lit("cfgacc_v", int'(s_v), 0);
    step(1, 12); lit("cfgacc_fill", s_fill, 1);
    step(1, 13);
    lit("cfgacc_lane", s_lane, 11);

    // Flush + i_valid + cfg in one cycle
    step(0, 0, 1, 1, 4);
    for (int n = 1; n <= 4; n++) step(1, n);
    step(1, 99, 1, 1, 2);
    lit("fl_drop_v", int'(s_v), 0);
    step(0, 0);
    lit("fl_fill", s_fill, 0);
    lit("fl_err", int'(s_e), 0);
    step(1, 7);
    step(1, 8); lit("fl_a8", int'(s_v), 0);
    step(1, 9);
    lit("fl_a9_v", int'(s_v), 1);
    lit("fl_a9_lane", s_lane, 7);

    // D=1
    step(0, 0, 1, 1, 1);
    step(1, 5); lit("d1_a5", int'(s_v), 0);
    step(1, 6); lit("d1_a6", s_lane, 5);
    step(1, 7); lit("d1_a7", s_lane, 6);
    lit("d1_a7_v", int'(s_v), 1);

    // Asynchronous reset mid-stream
    step(0, 0, 1, 1, 3);
    for (int n = 1; n <= 4; n++) step(1, n);
    i_valid = 1'b1;
    i_data  = vec(50);
    #1 rst = 1'b0;
    #1;
    lit("arst_fill", int'(o_fill), 0);
    lit("arst_valid", int'(o_valid), 0);
    chk("arst_data", o_data, '0);
    i_valid = 1'b0;
    i_data  = '0;
    q.delete();
    m_d     = MAX_DEPTH;
    exp_err = 1'b0;
    #1 rst = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step(1, n);
      lit("post_rst_v", int'(s_v), (n == 17) ? 1 : 0);
    end
    lit("post_rst_lane", s_lane, 1);

    step(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
